cbox16_control_unit: RTL

Multi-cycle control unit for the CBox16 processor: fetches 16-bit instructions over a request/valid handshake, decodes them, and drives the control inputs of the manual CPU datapath (register selects, write enable, load/store strobes, ALU op, writeback mux, immediate bus). It consumes the datapath flags Z/N/C/V, latches them into a flag register and resolves conditional branches. Together with the datapath it forms the complete CPU.

---
 rtl/cbox16_control_unit_if.sv | 25 ++
 rtl/cbox16_control_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cbox16_control_unit_if.sv
// Instruction-fetch bus between the CBox16 control unit and the instruction memory.
// The master, which is the control unit, raises IMEM_REQ and holds IMEM_ADDR stable.
// The slave, which is the memory, answers with IMEM_DATA qualified by IMEM_VALID.
interface cbox16_control_unit_if #(
    parameter int unsigned PC_W = 8
);
    logic [PC_W-1:0] IMEM_ADDR;
    logic            IMEM_REQ;
    logic [15:0]     IMEM_DATA;
    logic            IMEM_VALID;

    modport master (
        output IMEM_ADDR,
        output IMEM_REQ,
        input  IMEM_DATA,
        input  IMEM_VALID
    );

    modport slave (
        input  IMEM_ADDR,
        input  IMEM_REQ,
        output IMEM_DATA,
        output IMEM_VALID
    );
endinterface

// File: rtl/cbox16_control_unit.sv
// CBox16 multi-cycle control unit.
// It fetches an instruction over the imem handshake, decodes it and then sequences the datapath.
// States: IDLE -> FETCH -> DECODE -> EXEC [-> WB] -> FETCH. HLT goes to an absorbing HALT state.
// Optional feature: define CBOX16_CU_ILLEGAL_TRAP_EN to trap opcodes D/E into HALT.
// The trap also sets a sticky ILLEGAL flag. Without the macro, D/E execute as NOP.
module cbox16_control_unit #(
    parameter int unsigned    PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    cbox16_control_unit_if.master imem,
    output logic [2:0]            RS1,
    output logic [2:0]            RS2,
    output logic [2:0]            WS,
    output logic                  WE,
    output logic                  LDR,
    output logic                  STR,
    output logic [15:0]           IN,
    output logic [1:0]            ALUOP,
    output logic [1:0]            DMUX,
    input  logic                  Z,
    input  logic                  N,
    input  logic                  C,
    input  logic                  V,
    output logic                  HALTED,
    output logic                  ILLEGAL
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWb,
        StHalt
    } state_e;

    localparam logic [3:0] OpNop = 4'h0;
    localparam logic [3:0] OpAdd = 4'h1;
    localparam logic [3:0] OpSub = 4'h2;
    localparam logic [3:0] OpAnd = 4'h3;
    localparam logic [3:0] OpOr  = 4'h4;
    localparam logic [3:0] OpLdr = 4'h5;
    localparam logic [3:0] OpStr = 4'h6;
    localparam logic [3:0] OpLdi = 4'h7;
    localparam logic [3:0] OpB   = 4'h8;
    localparam logic [3:0] OpBeq = 4'h9;
    localparam logic [3:0] OpBne = 4'hA;
    localparam logic [3:0] OpBlt = 4'hB;
    localparam logic [3:0] OpBcs = 4'hC;
    localparam logic [3:0] OpHlt = 4'hF;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    // Flag register layout is {Z, N, C, V}.
    logic [3:0]      flags_q, flags_d;
    logic [2:0]      rs1_q, rs1_d;
    logic [2:0]      rs2_q, rs2_d;
    logic [2:0]      ws_q, ws_d;
    logic [15:0]     in_q, in_d;
    logic [1:0]      aluop_q, aluop_d;
    logic [1:0]      dmux_q, dmux_d;

    logic [3:0]      opcode;
    logic            is_alu;
    logic            is_trap;
    logic            branch_taken;
    logic [PC_W-1:0] off_ext;

    assign opcode = ir_q[15:12];
    assign is_alu = (opcode == OpAdd) || (opcode == OpSub) ||
                    (opcode == OpAnd) || (opcode == OpOr);

`ifdef CBOX16_CU_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign is_trap = (opcode == 4'hD) || (opcode == 4'hE);
    assign ILLEGAL = illegal_q;
`else
    assign is_trap = 1'b0;
    assign ILLEGAL = 1'b0;
`endif

    // The 12-bit branch offset is sign-extended or truncated to PC width. The add wraps mod 2^PC_W.
    for (genvar gi = 0; gi < PC_W; gi++) begin : g_off
        if (gi < 12) begin : g_bit
            assign off_ext[gi] = ir_q[gi];
        end else begin : g_sign
            assign off_ext[gi] = ir_q[11];
        end
    end

    // Branch condition evaluated against the latched flags only, never the live datapath flags.
    always_comb begin
        branch_taken = 1'b0;
        case (opcode)
            OpB:     branch_taken = 1'b1;
            OpBeq:   branch_taken = flags_q[3];
            OpBne:   branch_taken = ~flags_q[3];
            OpBlt:   branch_taken = flags_q[2] ^ flags_q[0];
            OpBcs:   branch_taken = flags_q[1];
            default: branch_taken = 1'b0;
        endcase
    end

    // Next-state logic for the sequencer and all registered decode outputs.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        ws_d    = ws_q;
        in_d    = in_q;
        aluop_d = aluop_q;
        dmux_d  = dmux_q;
`ifdef CBOX16_CU_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (imem.IMEM_VALID) begin
                    ir_d    = imem.IMEM_DATA;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                rs1_d = ir_q[8:6];
                rs2_d = ir_q[5:3];
                ws_d  = ir_q[11:9];
                in_d  = {7'b0, ir_q[8:0]};
                case (opcode)
                    OpSub:   aluop_d = 2'b01;
                    OpAnd:   aluop_d = 2'b10;
                    OpOr:    aluop_d = 2'b11;
                    default: aluop_d = 2'b00;
                endcase
                // DMUX is set once here. It then holds through EXEC and WB.
                case (opcode)
                    OpLdr:   dmux_d = 2'b01;
                    OpLdi:   dmux_d = 2'b10;
                    default: dmux_d = 2'b00;
                endcase
                if (opcode == OpHlt) begin
                    state_d = StHalt;
                end else if (is_trap) begin
                    state_d = StHalt;
`ifdef CBOX16_CU_ILLEGAL_TRAP_EN
                    illegal_d = 1'b1;
`endif
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (is_alu) begin
                    flags_d = {Z, N, C, V};
                end
                // The PC was already incremented during fetch. The offset is relative to PC+1.
                if (branch_taken) begin
                    pc_d = pc_q + off_ext;
                end
                state_d = (opcode == OpLdr) ? StWb : StFetch;
            end
            StWb: begin
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            flags_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            ws_q    <= '0;
            in_q    <= '0;
            aluop_q <= '0;
            dmux_q  <= '0;
`ifdef CBOX16_CU_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            ws_q    <= ws_d;
            in_q    <= in_d;
            aluop_q <= aluop_d;
            dmux_q  <= dmux_d;
`ifdef CBOX16_CU_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Strobes are decoded from the registered state and IR, so each one lasts exactly one cycle.
    always_comb begin
        WE  = ((state_q == StExec) && (is_alu || (opcode == OpLdi))) || (state_q == StWb);
        LDR = (state_q == StExec) && (opcode == OpLdr);
        STR = (state_q == StExec) && (opcode == OpStr);
    end

    assign imem.IMEM_ADDR = pc_q;
    assign imem.IMEM_REQ  = (state_q == StFetch);
    assign HALTED         = (state_q == StHalt);
    assign RS1            = rs1_q;
    assign RS2            = rs2_q;
    assign WS             = ws_q;
    assign IN             = in_q;
    assign ALUOP          = aluop_q;
    assign DMUX           = dmux_q;

    // OpNop needs no decode of its own. It just falls through EXEC back to FETCH.
    logic unused_nop;
    assign unused_nop = (opcode == OpNop);

endmodule
